// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register between core stages: pass, hold, bubble and flush
// of an opaque payload, with saturating bubble/hold performance counters.

module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module pipe_stage_reg #(
    parameter int                  DATA_W    = 64,
    parameter int                  STALL_W   = 6,
    parameter int                  STAGE_IDX = 2,
    parameter logic [DATA_W-1:0]   NOP_VALUE = {DATA_W{1'b0}},
    parameter int                  CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] ctrl_stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);
    logic up_stall;
    logic dn_stall;
    logic bubble;
    logic hold;

    assign up_stall = ctrl_stall[STAGE_IDX];

    // The last stage has no downstream stall bit; it can only bubble, never hold.
    generate
        if (STAGE_IDX >= STALL_W - 1) begin : g_top
            assign dn_stall = 1'b0;
        end else begin : g_mid
            assign dn_stall = ctrl_stall[STAGE_IDX+1];
        end
    endgenerate

    assign bubble = !flush && up_stall && !dn_stall;
    assign hold   = !flush && up_stall &&  dn_stall;

    // up_stall=0 always passes, even if downstream is stalled, so data is never dropped.
    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            out_data  <= NOP_VALUE;
            out_valid <= 1'b0;
        end else if (!up_stall) begin
            out_data  <= in_data;
            out_valid <= in_valid;
        end
    end

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (bubble),
        .cnt (bubble_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hold),
        .cnt (hold_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations (mid stage, 3-bit counters,
// top stage) driven in lockstep and compared against a cycle-level model.

module tb_pipe_stage_reg;
    localparam int DW = 64;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] ctrl_stall;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          cnt_clr;

    logic [DW-1:0] m_data, s_data, t_data;
    logic          m_valid, s_valid, t_valid;
    logic [15:0]   m_bub, m_hold, t_bub, t_hold;
    logic [2:0]    s_bub, s_hold;

    int n_assert = 0;
    int n_fail   = 0;

    // model state per instance: 0 = main, 1 = sat, 2 = top
    int            idx_a[3] = '{2, 2, 5};
    int            cw_a[3]  = '{16, 3, 16};
    logic [DW-1:0] e_data[3];
    logic          e_valid[3];
    longint        e_bub[3];
    longint        e_hold[3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(2), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .out_data(m_data), .out_valid(m_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(m_bub), .hold_cnt(m_hold));

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(2), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .out_data(s_data), .out_valid(s_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(s_bub), .hold_cnt(s_hold));

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(SW-1), .CNT_W(16)) u_top (
        .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .out_data(t_data), .out_valid(t_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(t_bub), .hold_cnt(t_hold));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Action chosen from the stall/flush rules, then applied to the model.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit up, dn;
            longint mx;
            string act;
            mx = (64'd1 << cw_a[i]) - 1;
            up = ctrl_stall[idx_a[i]];
            dn = (idx_a[i] + 1 < SW) ? ctrl_stall[idx_a[i]+1] : 1'b0;
            if (rst)            act = "reset";
            else if (flush)     act = "flush";
            else if (up && !dn) act = "bubble";
            else if (!up)       act = "pass";
            else                act = "hold";
            case (act)
                "reset", "flush", "bubble": begin e_data[i] = '0; e_valid[i] = 1'b0; end
                "pass":                     begin e_data[i] = in_data; e_valid[i] = in_valid; end
                default: ;
            endcase
            if (rst || cnt_clr) begin
                e_bub[i] = 0;
                e_hold[i] = 0;
            end else begin
                if (act == "bubble") e_bub[i]  = (e_bub[i]  >= mx) ? mx : e_bub[i] + 1;
                if (act == "hold")   e_hold[i] = (e_hold[i] >= mx) ? mx : e_hold[i] + 1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":main.data"},  m_data,  e_data[0]);
        chk({ph, ":main.valid"}, {63'd0, m_valid}, {63'd0, e_valid[0]});
        chk({ph, ":main.bub"},   {48'd0, m_bub},  e_bub[0]);
        chk({ph, ":main.hold"},  {48'd0, m_hold}, e_hold[0]);
        chk({ph, ":sat.data"},   s_data,  e_data[1]);
        chk({ph, ":sat.valid"},  {63'd0, s_valid}, {63'd0, e_valid[1]});
        chk({ph, ":sat.bub"},    {61'd0, s_bub},  e_bub[1]);
        chk({ph, ":sat.hold"},   {61'd0, s_hold}, e_hold[1]);
        chk({ph, ":top.data"},   t_data,  e_data[2]);
        chk({ph, ":top.valid"},  {63'd0, t_valid}, {63'd0, e_valid[2]});
        chk({ph, ":top.bub"},    {48'd0, t_bub},  e_bub[2]);
        chk({ph, ":top.hold"},   {48'd0, t_hold}, e_hold[2]);
    endtask

    // Inputs change only #1 after a posedge; the model sees the values sampled at the edge.
    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic drive(input logic r, input logic [SW-1:0] st, input logic fl,
                         input logic [DW-1:0] d, input logic v, input logic cl);
        rst = r; ctrl_stall = st; flush = fl; in_data = d; in_valid = v; cnt_clr = cl;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            e_data[i] = 'x; e_valid[i] = 1'bx; e_bub[i] = 0; e_hold[i] = 0;
        end

        // reset for two cycles, then first data after release
        drive(1, '0, 0, 64'hDEAD, 1, 0);
        step("reset");
        step("reset");
        chk("reset.bub_const", {48'd0, m_bub}, 64'd0);
        drive(0, '0, 0, 64'hDEAD, 1, 0);
        step("release");
        chk("release.data_const", m_data, 64'hDEAD);

        // pass stream
        for (int k = 1; k <= 3; k++) begin
            drive(0, '0, 0, 64'(k), 1, 0);
            step("pass");
            chk("pass.data_const", m_data, 64'(k));
        end

        // bubble for three cycles (upstream stage 2 stalled)
        for (int k = 0; k < 3; k++) begin
            drive(0, 6'b000100, 0, 64'h55, 1, 0);
            step("bubble");
        end
        chk("bubble.cnt_const", {48'd0, m_bub}, 64'd3);
        chk("bubble.hold_const", {48'd0, m_hold}, 64'd0);

        // hold then flush with stalls still asserted, then hold the NOP
        drive(0, '0, 0, 64'hAA, 1, 0);
        step("load");
        for (int k = 0; k < 4; k++) begin
            drive(0, 6'b001100, 0, 64'h100 + 64'(k), 1, 0);
            step("hold");
        end
        chk("hold.data_const", m_data, 64'hAA);
        chk("hold.cnt_const", {48'd0, m_hold}, 64'd4);
        drive(0, 6'b001100, 1, 64'h77, 1, 0);
        step("hold_flush");
        chk("hold_flush.cnt_const", {48'd0, m_hold}, 64'd4);
        drive(0, 6'b001100, 0, 64'h78, 1, 0);
        step("hold_nop");
        step("hold_nop");

        // saturation of 3-bit counters, clear during bubble, then count again
        for (int k = 0; k < 10; k++) begin
            drive(0, 6'b000100, 0, 64'(k), 1, 0);
            step("sat");
        end
        chk("sat.bub_const", {61'd0, s_bub}, 64'd7);
        drive(0, 6'b000100, 0, 64'h9, 1, 1);
        step("clr");
        chk("clr.bub_const", {61'd0, s_bub}, 64'd0);
        drive(0, 6'b000100, 0, 64'h9, 1, 0);
        step("after_clr");
        chk("after_clr.bub_const", {61'd0, s_bub}, 64'd1);

        // top stage: its stall bit alone only ever bubbles
        for (int k = 0; k < 4; k++) begin
            drive(0, 6'b110000, 0, 64'hF0 + 64'(k), 1, 0);
            step("top");
        end
        chk("top.hold_const", {48'd0, t_hold}, 64'd0);

        // randomized mix; stalls biased so holds and saturation both occur
        for (int k = 0; k < 400; k++) begin
            logic [SW-1:0] st;
            st = SW'($urandom);
            if ($urandom_range(0, 2) == 0) st[3:2] = 2'b11;
            drive(($urandom_range(0, 60) == 0), st, ($urandom_range(0, 9) == 0),
                  {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 30) == 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for the five-stage core, replacing the hand-written per-stage registers between IF/ID/EX/MEM/WB. It carries an opaque payload plus a valid bit from one stage to the next. It takes its stage index into the controller stall vector as a parameter and handles pass, hold, bubble insertion and synchronous flush. Saturating bubble and hold counters feed performance monitoring.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (≥1)
- STALL_W, 6, width of the controller stall vector
- STAGE_IDX, 2, index of the upstream (producing) stage in ctrl_stall; the downstream stage is STAGE_IDX+1
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on reset, flush and bubble
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- ctrl_stall  input  STALL_W  per-stage stall flags from ctrl; 1 = stalled
- flush  input  1  synchronous kill of the stage contents
- in_data  input  DATA_W  payload from the upstream stage
- in_valid  input  1  upstream payload is a real instruction
- out_data  output  DATA_W  registered payload to the downstream stage
- out_valid  output  1  registered valid
- cnt_clr  input  1  synchronous clear of both counters
- bubble_cnt  output  CNT_W  number of bubbles inserted (saturating)
- hold_cnt  output  CNT_W  number of hold cycles (saturating)

## Operation
Definitions:
- up_stall = ctrl_stall[STAGE_IDX]
- dn_stall = ctrl_stall[STAGE_IDX+1]. If STAGE_IDX = STALL_W-1, dn_stall is constant 0.

Register update, one action per cycle, in strict priority order:
1. RESET (rst=1): out_data=NOP_VALUE, out_valid=0, bubble_cnt=0, hold_cnt=0.
2. FLUSH (flush=1): out_data=NOP_VALUE, out_valid=0. Flush overrides every stall combination, including a hold.
3. BUBBLE (up_stall=1, dn_stall=0): out_data=NOP_VALUE, out_valid=0.
4. PASS (up_stall=0): out_data=in_data, out_valid=in_valid. This covers up_stall=0 with dn_stall=1, which ctrl never issues. Behaviour in that case is defined as PASS so that in-flight data is never dropped silently.
5. HOLD (up_stall=1, dn_stall=1): out_data and out_valid keep their values.

Counters, when not in reset:
- cnt_clr=1: both counters go to 0. No increment happens in that cycle.
- Otherwise bubble_cnt increments by 1 in every BUBBLE cycle.
- Otherwise hold_cnt increments by 1 in every HOLD cycle.
- Flush cycles increment neither counter.
- Both counters saturate at 2^CNT_W-1 and never wrap.

Other rules:
- The payload is opaque. No field of in_data is decoded.
- out_valid is a qualifier only. A bubble with NOP_VALUE payload and out_valid=0 must be harmless downstream even if out_valid is ignored.

## Timing
- Latency is 1 cycle: in_data/in_valid sampled at edge N appear on out_data/out_valid after edge N.
- All outputs are registered. There are no combinational paths from any input to any output.
- Reset takes effect at the first posedge with rst=1. Outputs hold their reset values while rst stays high. Normal operation resumes on the first edge with rst=0.
- Reset mid-hold discards the held payload.
- flush and ctrl_stall are sampled on the same edge. Flush wins.
- After a flush in a cycle with up_stall=dn_stall=1, the stage then holds the NOP (out_valid=0) until dn_stall drops. Those later cycles count as HOLD.
- A counter at saturation together with cnt_clr=1 goes to 0.
- cnt_clr with rst=0 does not touch out_data or out_valid.

## Test plan
- Reset: assert rst for 2 cycles with in_data=0xDEAD, in_valid=1, ctrl_stall=0 -> out_data=NOP_VALUE, out_valid=0, both counters 0. First edge after release -> out_data=0xDEAD, out_valid=1.
- Pass stream: ctrl_stall=0, feed 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 exactly one cycle later each, out_valid=1 throughout.
- Bubble: STAGE_IDX=2, ctrl_stall=6'b000100 for 3 cycles with in_data=0x55 -> out_data=NOP_VALUE, out_valid=0 each cycle, bubble_cnt=3, hold_cnt=0.
- Hold plus flush: load 0xAA, then ctrl_stall=6'b001100 for 4 cycles with in_data changing -> out_data stays 0xAA, hold_cnt=4. Then assert flush for 1 cycle with stalls still held -> out_data=NOP_VALUE, out_valid=0, hold_cnt unchanged in the flush cycle.
- Saturation and clear: CNT_W=3, 10 bubble cycles -> bubble_cnt=7. Then cnt_clr=1 during a bubble cycle -> bubble_cnt=0. The next bubble gives bubble_cnt=1.
- Top-stage edge: STAGE_IDX=STALL_W-1, ctrl_stall[STALL_W-1]=1 -> BUBBLE every cycle, never HOLD. hold_cnt stays 0.
